sdram_frame_arbiter: RTL and testbench

Burst scheduler between the camera FIFO (write requester), the VGA FIFO (read requester) and the single-port `sdram_controller`. It decides which side owns each full-page SDRAM transaction and drives `rw`/`rw_en`/address. It pops the camera FIFO and pushes the VGA FIFO word by word from the controller's data-valid strobes. It also keeps per-frame page counters and frame IDs so the VGA side always reads a completed frame, and raises the first-frame flag that enables VGA output.

---
 rtl/sdram_frame_arbiter.sv | 158 +++++++++++++++
 tb/tb_sdram_frame_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_arbiter.sv
// Page-burst scheduler between the camera FIFO (writes) and the VGA FIFO (reads) on one SDRAM port.
// Define SDRAM_ARB_TRIPLE_BUF_EN for three rotating frame regions; otherwise one region is shared.
module sdram_frame_arbiter #(
    parameter int DATA_WD     = 16,
    parameter int ADDR_WD     = 14,
    parameter int CNT_WD      = 11,
    parameter int FIFO_DEPTH  = 2048,
    parameter int PAGE_WORDS  = 256,
    parameter int FRAME_PAGES = 1200,
    parameter int RD_URGENT   = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [CNT_WD-1:0]  wr_cnt_i,
    input  logic [CNT_WD-1:0]  rd_cnt_i,
    input  logic               ready_i,
    input  logic               fpga_data_valid_i,
    input  logic               sd_data_valid_i,
    output logic               rw_o,
    output logic               rw_en_o,
    output logic [ADDR_WD-1:0] addr_o,
    output logic               rd_src_fifo_o,
    output logic               wr_dst_fifo_o,
    output logic [1:0]         wr_frame_o,
    output logic [1:0]         rd_frame_o,
    output logic               first_frame_o
);

    localparam int WORD_WD = $clog2(PAGE_WORDS + 1);
    localparam int PAGE_WD = $clog2(FRAME_PAGES);
    localparam logic [CNT_WD:0]      PW_C     = (CNT_WD+1)'(PAGE_WORDS);
    localparam logic [CNT_WD:0]      DEPTH_M1 = (CNT_WD+1)'(FIFO_DEPTH - 1);
    localparam logic [CNT_WD:0]      URG_C    = (CNT_WD+1)'(RD_URGENT);
    localparam logic [WORD_WD-1:0]   WORD_END = WORD_WD'(PAGE_WORDS - 1);
    localparam logic [PAGE_WD-1:0]   PAGE_END = PAGE_WD'(FRAME_PAGES - 1);

    if (DATA_WD <= 0) begin : g_bad_data_wd
        $error("DATA_WD must be positive");
    end

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t               state, state_nxt;
    logic [WORD_WD-1:0]   word_cnt;
    logic [PAGE_WD-1:0]   wr_page, rd_page;
    logic                 last_grant;  // 1 = last grant was a read
    logic                 wr_pend, rd_pend, urgent;
    logic                 grant_wr, grant_rd;
    logic                 wr_valid, rd_valid, word_last, wr_done, rd_done, wr_page_last;
    logic [CNT_WD:0]      rd_cnt_ext, rd_space;
    logic [ADDR_WD-1:0]   wr_base, rd_base, addr_nxt;

    assign rd_cnt_ext   = {1'b0, rd_cnt_i};
    assign rd_space     = DEPTH_M1 - rd_cnt_ext;
    assign wr_pend      = {1'b0, wr_cnt_i} >= PW_C;
    assign rd_pend      = first_frame_o && (rd_cnt_ext <= DEPTH_M1) && (rd_space >= PW_C);
    assign urgent       = rd_pend && (rd_cnt_ext < URG_C);

    // Strobes only count while the matching burst owns the controller.
    assign wr_valid      = (state == WR_BURST) && fpga_data_valid_i;
    assign rd_valid      = (state == RD_BURST) && sd_data_valid_i;
    assign word_last     = word_cnt == WORD_END;
    assign wr_done       = wr_valid && word_last;
    assign rd_done       = rd_valid && word_last;
    assign wr_page_last  = wr_page == PAGE_END;
    assign rd_src_fifo_o = wr_valid;
    assign wr_dst_fifo_o = rd_valid;

    always_comb begin
        state_nxt = state;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (ready_i) begin
                    if (urgent)                  grant_rd = 1'b1;
                    else if (wr_pend && rd_pend) begin
                        grant_wr = last_grant;
                        grant_rd = !last_grant;
                    end
                    else if (wr_pend)            grant_wr = 1'b1;
                    else if (rd_pend)            grant_rd = 1'b1;
                end
                if (grant_wr)      state_nxt = WR_BURST;
                else if (grant_rd) state_nxt = RD_BURST;
            end
            WR_BURST: if (wr_done) state_nxt = IDLE;
            RD_BURST: if (rd_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

`ifdef SDRAM_ARB_TRIPLE_BUF_EN
    localparam logic [ADDR_WD-1:0] FP_A = ADDR_WD'(FRAME_PAGES);

    logic [1:0] wr_frame, rd_frame, last_done, last_done_nxt, rd_frame_sel;

    // A reader starting a new frame sees a frame completed in the same cycle.
    assign last_done_nxt = (wr_done && wr_page_last) ? wr_frame : last_done;
    assign rd_frame_sel  = (rd_page == '0) ? last_done_nxt : rd_frame;
    assign wr_base       = ADDR_WD'(wr_frame) * FP_A;
    assign rd_base       = ADDR_WD'(rd_frame_sel) * FP_A;
    assign wr_frame_o    = wr_frame;
    assign rd_frame_o    = rd_frame;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_frame  <= '0;
            rd_frame  <= '0;
            last_done <= '0;
        end else begin
            last_done <= last_done_nxt;
            if (wr_done && wr_page_last)
                wr_frame <= (wr_frame == 2'd2) ? 2'd0 : wr_frame + 2'd1;
            if (grant_rd)
                rd_frame <= rd_frame_sel;
        end
    end
`else
    assign wr_base    = '0;
    assign rd_base    = '0;
    assign wr_frame_o = '0;
    assign rd_frame_o = '0;
`endif

    assign addr_nxt = grant_rd ? rd_base + ADDR_WD'(rd_page) : wr_base + ADDR_WD'(wr_page);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            word_cnt      <= '0;
            wr_page       <= '0;
            rd_page       <= '0;
            last_grant    <= 1'b1;
            rw_en_o       <= 1'b0;
            rw_o          <= 1'b0;
            addr_o        <= '0;
            first_frame_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            rw_en_o <= grant_wr || grant_rd;
            if (grant_wr || grant_rd) begin
                rw_o       <= grant_rd;
                last_grant <= grant_rd;
                addr_o     <= addr_nxt;
            end
            if (wr_valid || rd_valid)
                word_cnt <= word_last ? '0 : word_cnt + 1'b1;
            if (wr_done) begin
                wr_page <= wr_page_last ? '0 : wr_page + 1'b1;
                if (wr_page_last) first_frame_o <= 1'b1;
            end
            if (rd_done)
                rd_page <= (rd_page == PAGE_END) ? '0 : rd_page + 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Directed bench for sdram_frame_arbiter; short pages keep multi-frame runs cheap.
module tb_sdram_frame_arbiter;
    localparam int PW = 4;
    localparam int FP = 1200;
`ifdef SDRAM_ARB_TRIPLE_BUF_EN
    localparam bit TRIPLE = 1'b1;
`else
    localparam bit TRIPLE = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic [10:0] wr_cnt = '0, rd_cnt = '0;
    logic        ready = 1'b0, fdv = 1'b0, sdv = 1'b0;
    logic        rw, rw_en, pop, push, ff;
    logic [13:0] addr;
    logic [1:0]  wf, rf;

    int errors = 0, checks = 0;
    int m_wp = 0, m_wf = 0, m_done = 0, m_rp = 0, m_rf = 0, n_wtot = 0;
    int n_rd, n_wr, n_lat, n_alt, n_addr, n_tear, n_short, n_en;
    int a_f2p5 = -1;
    bit prev_r;

    sdram_frame_arbiter #(.PAGE_WORDS(PW), .FRAME_PAGES(FP)) dut (
        .clk_i(clk), .rst_i(rst), .wr_cnt_i(wr_cnt), .rd_cnt_i(rd_cnt), .ready_i(ready),
        .fpga_data_valid_i(fdv), .sd_data_valid_i(sdv), .rw_o(rw), .rw_en_o(rw_en),
        .addr_o(addr), .rd_src_fifo_o(pop), .wr_dst_fifo_o(push), .wr_frame_o(wf),
        .rd_frame_o(rf), .first_frame_o(ff)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int exp_addr(input bit r);
        return r ? (TRIPLE ? m_rf * FP : 0) + m_rp : (TRIPLE ? m_wf * FP : 0) + m_wp;
    endfunction

    task automatic model_start(input bit r);
        if (r && m_rp == 0) m_rf = m_done;
    endtask

    task automatic model_done(input bit r);
        if (r) m_rp = (m_rp == FP - 1) ? 0 : m_rp + 1;
        else begin
            n_wtot++;
            if (m_wp == FP - 1) begin
                m_wp = 0; m_done = m_wf; m_wf = (m_wf + 1) % 3;
            end else m_wp++;
        end
    endtask

    task automatic clr();
        n_rd = 0; n_wr = 0; n_lat = 0; n_alt = 0; n_addr = 0; n_tear = 0; n_short = 0; n_en = 0;
    endtask

    task automatic grant(output bit r, output int a, output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (rw_en !== 1'b1 && cyc < 50);
        if (rw_en !== 1'b1) chk("grant_timeout", {31'd0, rw_en}, 1);
        r = rw; a = int'(addr);
    endtask

    // Feed PW data strobes to the side that owns the burst; wrong-side strobes poison the count.
    task automatic burst(input bit r);
        int s = 0;
        for (int i = 0; i < PW; i++) begin
            @(negedge clk);
            if (r) sdv = 1'b1; else fdv = 1'b1;
            #1;
            if (r ? push : pop) s++;
            if (r ? pop : push) s += 100;
            if (rw_en) n_en++;
        end
        @(negedge clk);
        fdv = 1'b0; sdv = 1'b0;
        if (s != PW) n_short++;
    endtask

    task automatic one(input string tag, input bit exp_r, output int a);
        bit r; int cyc;
        grant(r, a, cyc);
        chk({tag, "_rw"}, {31'd0, r}, {31'd0, exp_r});
        model_start(r);
        chk({tag, "_addr"}, a, exp_addr(r));
        burst(r);
        model_done(r);
    endtask

    task automatic run(input int n);
        bit r; int a, cyc;
        for (int i = 0; i < n; i++) begin
            grant(r, a, cyc);
            if (r) n_rd++; else n_wr++;
            if (cyc != 1) n_lat++;
            if (r == prev_r) n_alt++;
            prev_r = r;
            model_start(r);
            if (!r && n_wtot == 2405) a_f2p5 = a;
            if (a != exp_addr(r)) n_addr++;
            if (TRIPLE && rf == wf) n_tear++;
            burst(r);
            model_done(r);
        end
    endtask

    initial begin
        bit r; int a, cyc;
        clr();
        rst = 1'b1; wr_cnt = 11'd300; rd_cnt = 11'd0; ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rw_en", {31'd0, rw_en}, 0);
        chk("rst_addr", {18'd0, addr}, 0);
        chk("rst_ff", {31'd0, ff}, 0);
        chk("rst_pop", {31'd0, pop}, 0);
        rst = 1'b0;

        grant(r, a, cyc);
        chk("first_lat", cyc, 1);
        chk("first_rw", {31'd0, r}, 0);
        chk("first_addr", a, 0);
        burst(1'b0);
        model_done(1'b0);
        chk("first_pops_ok", n_short, 0);
        chk("rw_en_one_cycle", n_en, 0);

        // Strobes with the FSM idle must not pop, push or count.
        wr_cnt = 11'd0;
        @(negedge clk); fdv = 1'b1; sdv = 1'b1; #1;
        chk("idle_pop", {31'd0, pop}, 0);
        chk("idle_push", {31'd0, push}, 0);
        @(negedge clk); fdv = 1'b0; sdv = 1'b0;
        chk("idle_no_grant", {31'd0, rw_en}, 0);
        wr_cnt = 11'd300;
        one("page1", 1'b0, a);
        chk("page1_full", n_short, 0);

        // Rest of frame 0: reads are locked out until the first frame lands.
        clr(); prev_r = 1'b1;
        run(FP - 2);
        chk("pre_ff_reads", n_rd, 0);
        chk("pre_ff_addr", n_addr, 0);
        chk("pre_ff_short", n_short, 0);
        chk("pre_ff_b2b", n_lat, 0);
        chk("ff_set", {31'd0, ff}, 1);
        chk("wf_after_f0", {30'd0, wf}, TRIPLE ? 1 : 0);

        one("urg_rd", 1'b1, a);
        chk("urg_rd_addr0", a, 0);
        chk("urg_rd_rf", {30'd0, rf}, 0);
        rd_cnt = 11'd1000;
        one("alt_w", 1'b0, a);
        chk("wrap_addr", a, TRIPLE ? 1200 : 0);
        one("alt_r", 1'b1, a);
        chk("alt_r_addr", a, 1);
        one("alt_w2", 1'b0, a);
        one("alt_r2", 1'b1, a);
        rd_cnt = 11'd100;
        one("urg_rr", 1'b1, a);
        rd_cnt = 11'd1000;

        // Interleaved traffic up to 3600 written pages.
        clr(); prev_r = 1'b1;
        run(2 * (3 * FP - n_wtot));
        chk("alt_pattern", n_alt, 0);
        chk("run_addr", n_addr, 0);
        chk("run_tear", n_tear, 0);
        chk("run_b2b", n_lat, 0);
        chk("run_short", n_short, 0);
        chk("run_en", n_en, 0);
        chk("addr_f2p5", a_f2p5, TRIPLE ? 2405 : 5);
        chk("wf_final", {30'd0, wf}, 0);

        // Reset in the middle of a read burst.
        rd_cnt = 11'd100;
        grant(r, a, cyc);
        chk("mid_rw", {31'd0, r}, 1);
        repeat (2) begin @(negedge clk); sdv = 1'b1; end
        @(negedge clk); sdv = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_rw_en", {31'd0, rw_en}, 0);
        chk("rst_mid_rw", {31'd0, rw}, 0);
        chk("rst_mid_addr", {18'd0, addr}, 0);
        chk("rst_mid_push", {31'd0, push}, 0);
        chk("rst_mid_ff", {31'd0, ff}, 0);
        chk("rst_mid_frames", {28'd0, wf, rf}, 0);
        rst = 1'b0;
        m_wp = 0; m_wf = 0; m_done = 0; m_rp = 0; m_rf = 0;
        clr();
        one("post_rst", 1'b0, a);
        chk("post_rst_words", n_short, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
